// File: rtl/ifu_multicycle.sv
// rtl/ifu_multicycle.sv - multi-cycle instruction fetch unit with loader port
// Holds pc and a word-addressed instruction memory; fetch and pc update run off a phase counter.
module ifu_multicycle #(
  parameter int          IMEM_DEPTH   = 32,
  parameter int          PHASES       = 6,
  parameter int          FETCH_PHASE  = 1,
  parameter int          UPDATE_PHASE = 5,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          PW           = 3,
  parameter int          AW           = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          pc_w,
  input  logic          pc_a,
  input  logic          b_succ,
  input  logic [31:0]   wd,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic [31:0]   od,
  output logic [31:0]   pc,
  output logic          od_valid,
  output logic [PW-1:0] phase,
  output logic          fault
);

  localparam logic [PW-1:0] LAST_P   = PW'(PHASES - 1);
  localparam logic [PW-1:0] FETCH_P  = PW'(FETCH_PHASE);
  localparam logic [PW-1:0] UPDATE_P = PW'(UPDATE_PHASE);

  logic [31:0]   mem_q [IMEM_DEPTH];
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   od_q, od_d;
  logic          od_valid_q, od_valid_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          fault_q, fault_d;
  logic          pc_in_range;
  logic [31:0]   fetch_word;

  // Loader writes are independent of reset and stall so memory can be filled while the core is held.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  assign pc_in_range = (pc_q[31:AW+2] == '0);
  assign fetch_word  = mem_q[pc_q[AW+1:2]];

  always_comb begin
    phase_d    = phase_q;
    pc_d       = pc_q;
    od_d       = od_q;
    od_valid_d = od_valid_q;
    fault_d    = fault_q;
    if (!stall) begin
      phase_d = (phase_q == LAST_P) ? '0 : phase_q + 1'b1;
      if (phase_q == FETCH_P) begin
        od_valid_d = 1'b1;
        if (pc_in_range) begin
          od_d = fetch_word;
        end else begin
          od_d    = 32'h0;
          fault_d = 1'b1;
        end
      end
      if (phase_q == UPDATE_P) begin
        od_valid_d = 1'b0;
        if (pc_w) begin
          pc_d = {wd[31:2], 2'b00};
        end else if (pc_a && b_succ) begin
          pc_d = pc_q + 32'd4 + {wd[29:0], 2'b00};
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      od_q       <= 32'h0;
      od_valid_q <= 1'b0;
      phase_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      od_q       <= od_d;
      od_valid_q <= od_valid_d;
      phase_q    <= phase_d;
      fault_q    <= fault_d;
    end
  end

  assign pc       = pc_q;
  assign od       = od_q;
  assign od_valid = od_valid_q;
  assign phase    = phase_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_ifu_multicycle.sv
// tb/tb_ifu_multicycle.sv - self-checking bench for ifu_multicycle
// Expected fetch words are queued at each pc update and popped when od_valid rises.
module tb_ifu_multicycle;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, stall, pc_w, pc_a, b_succ, ld_en;
  logic [31:0]   wd, ld_data;
  logic [AW-1:0] ld_addr;
  logic [31:0]   od, pc;
  logic          od_valid, fault;
  logic [2:0]    phase;

  int          tests = 0;
  int          fails = 0;
  int          edges = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_m [32];

  ifu_multicycle dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_w(pc_w), .pc_a(pc_a),
    .b_succ(b_succ), .wd(wd), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .od(od), .pc(pc), .od_valid(od_valid), .phase(phase), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] fetch_exp(input logic [31:0] a);
    return (a[31:7] == 25'h0) ? mem_m[a[6:2]] : 32'h0;
  endfunction

  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    #1;
    edges++;
    if (od_valid === 1'b1 && prev_valid !== 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_empty od=%h", od);
      end else begin
        e = exp_q.pop_front();
        if (od !== e) begin
          fails++;
          $display("FAIL sb_fetch od=%h expected=%h pc=%h", od, e, pc);
        end
      end
    end
    prev_valid = od_valid;
  endtask

  // Garbage on the control inputs outside the update phase must be ignored.
  task automatic run_to(input logic [2:0] p);
    int n = 0;
    while (phase !== p && n < 20) begin
      pc_w = (phase != 3'd5); pc_a = (phase != 3'd5); b_succ = (phase != 3'd5);
      wd = 32'hFFFF_FFF0;
      step();
      n++;
    end
    pc_w = 0; pc_a = 0; b_succ = 0; wd = 0;
    if (phase !== p) begin
      tests++; fails++;
      $display("FAIL run_to phase=%0d expected=%0d", phase, p);
    end
  endtask

  task automatic do_update(input logic pw, input logic pa, input logic bs,
                           input logic [31:0] w, input logic [31:0] e);
    run_to(3'd5);
    pc_w = pw; pc_a = pa; b_succ = bs; wd = w;
    step();
    pc_w = 0; pc_a = 0; b_succ = 0; wd = 0;
    tests++;
    if (pc !== e) begin fails++; $display("FAIL update_pc pc=%h expected=%h", pc, e); end
    tests++;
    if (od_valid !== 1'b0) begin fails++; $display("FAIL update_valid od_valid=%b expected=0", od_valid); end
    exp_q.push_back(fetch_exp(e));
  endtask

  task automatic test_reset();
    logic [2:0] seq [8];
    seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
    reset = 1; stall = 0; pc_w = 0; pc_a = 0; b_succ = 0; wd = 0;
    for (int i = 0; i < 32; i++) begin
      ld_en = 1; ld_addr = AW'(i);
      ld_data = (i == 0) ? 32'h0022_8021 : (i == 1) ? 32'h0022_8823 : (32'hC0DE_0000 | 32'(i));
      mem_m[i] = ld_data;
      step();
    end
    ld_en = 0;
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rst_pc pc=%h expected=0", pc); end
    tests++; if (od !== 32'h0) begin fails++; $display("FAIL rst_od od=%h expected=0", od); end
    tests++; if (od_valid !== 1'b0) begin fails++; $display("FAIL rst_valid od_valid=%b expected=0", od_valid); end
    tests++; if (phase !== 3'd0) begin fails++; $display("FAIL rst_phase phase=%0d expected=0", phase); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL rst_fault fault=%b expected=0", fault); end
    exp_q.push_back(32'h0022_8021);
    reset = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      tests++;
      if (phase !== seq[k-1]) begin fails++; $display("FAIL phase_seq edge=%0d phase=%0d expected=%0d", k, phase, seq[k-1]); end
      if (k == 2) begin
        tests++;
        if (od_valid !== 1'b1) begin fails++; $display("FAIL first_fetch_valid od_valid=%b expected=1", od_valid); end
      end
      if (k == 6) begin
        tests++;
        if (pc !== 32'h4) begin fails++; $display("FAIL first_update_pc pc=%h expected=4", pc); end
        tests++;
        if (od_valid !== 1'b0 || od !== 32'h0022_8021) begin
          fails++; $display("FAIL first_update_od od=%h valid=%b expected=00228021/0", od, od_valid);
        end
        exp_q.push_back(32'h0022_8823);
      end
    end
  endtask

  task automatic test_branch();
    do_update(1, 0, 0, 32'h20, 32'h20);         run_to(3'd2);
    do_update(0, 1, 1, 32'h4, 32'h34);          run_to(3'd2);
    do_update(1, 0, 0, 32'h20, 32'h20);         run_to(3'd2);
    do_update(0, 1, 1, 32'hFFFF_FFFE, 32'h1C);  run_to(3'd2);
    do_update(1, 0, 0, 32'h20, 32'h20);         run_to(3'd2);
    do_update(0, 1, 0, 32'h4, 32'h24);          run_to(3'd2);
  endtask

  task automatic test_jump();
    do_update(1, 1, 1, 32'h43, 32'h40);
    run_to(3'd2);
  endtask

  task automatic test_stall();
    int e0;
    logic [31:0] od_s;
    do_update(0, 0, 0, 32'h0, 32'h44);
    e0 = edges;
    run_to(3'd1);
    od_s = od;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      pc_w = 1; wd = 32'h100;
      step();
      tests++;
      if (phase !== 3'd1 || pc !== 32'h44 || od_valid !== 1'b0 || od !== od_s) begin
        fails++;
        $display("FAIL stall_hold phase=%0d pc=%h valid=%b od=%h expected=1/00000044/0/%h", phase, pc, od_valid, od, od_s);
      end
    end
    pc_w = 0; wd = 0; stall = 0;
    step();
    tests++;
    if (od_valid !== 1'b1 || phase !== 3'd2) begin
      fails++; $display("FAIL stall_release valid=%b phase=%0d expected=1/2", od_valid, phase);
    end
    do_update(0, 0, 0, 32'h0, 32'h48);
    tests++;
    if (edges - e0 !== 9) begin fails++; $display("FAIL stall_cycle_len clocks=%0d expected=9", edges - e0); end
    run_to(3'd2);
  endtask

  task automatic test_fault();
    do_update(1, 0, 0, 32'h80, 32'h80);
    run_to(3'd2);
    tests++;
    if (fault !== 1'b1 || od_valid !== 1'b1) begin
      fails++; $display("FAIL fault_set fault=%b valid=%b expected=1/1", fault, od_valid);
    end
    do_update(1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    run_to(3'd2);
    do_update(0, 0, 0, 32'h0, 32'h0);
    run_to(3'd2);
    tests++;
    if (fault !== 1'b1) begin fails++; $display("FAIL fault_sticky fault=%b expected=1", fault); end
  endtask

  task automatic test_back_to_back();
    do_update(1, 0, 0, 32'h08, 32'h08);
    run_to(3'd1);
    ld_en = 1; ld_addr = 5'd2; ld_data = 32'h5555_AAAA;
    step();
    ld_en = 0;
    mem_m[2] = 32'h5555_AAAA;
    run_to(3'd3);
    reset = 1; ld_en = 1; ld_addr = 5'd3; ld_data = 32'h1234_5678;
    step();
    reset = 0; ld_en = 0;
    mem_m[3] = 32'h1234_5678;
    tests++;
    if (pc !== 32'h0 || phase !== 3'd0 || od !== 32'h0 || od_valid !== 1'b0 || fault !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset pc=%h phase=%0d od=%h valid=%b fault=%b expected=0/0/0/0/0", pc, phase, od, od_valid, fault);
    end
    exp_q.delete();
    exp_q.push_back(mem_m[0]);
    run_to(3'd2);
    do_update(1, 0, 0, 32'h0C, 32'h0C); run_to(3'd2);
    do_update(1, 0, 0, 32'h08, 32'h08); run_to(3'd2);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL sb_leftover size=%0d expected=0", exp_q.size()); end
  endtask

  initial begin
    reset = 1; stall = 0; pc_w = 0; pc_a = 0; b_succ = 0; wd = 0;
    ld_en = 0; ld_addr = '0; ld_data = 0;
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_fault();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifu_multicycle.md
Name: ifu_multicycle

Overview:
Parametrised instruction-fetch unit for the multi-cycle MIPS core. It holds the PC and a word-addressed instruction memory, and sequences fetch and PC update on an internal phase counter with configurable length. Compared with the earlier fixed unit, it adds a loader write port, a stall input, an instruction-valid flag, aligned jumps and an out-of-range fetch fault. It sits between the controller (pc_w, pc_a, stall) and the decoder/register file (od, pc).

Parameters:
IMEM_DEPTH, 32, instruction memory depth in 32-bit words; power of 2, >=2; AW = log2(IMEM_DEPTH)
PHASES, 6, length of one instruction cycle in clocks; >=2
FETCH_PHASE, 1, phase value at which the instruction is read
UPDATE_PHASE, 5, phase value at which pc is updated; must satisfy FETCH_PHASE < UPDATE_PHASE < PHASES
RESET_PC, 32'h0, pc value loaded on reset; word aligned
PW, 3, phase counter width; must satisfy 2^PW >= PHASES

Ports:
clk  in  1  system clock; all state changes on posedge clk
reset  in  1  synchronous, active-high reset
stall  in  1  freezes phase counter, fetch and pc update while high
pc_w  in  1  jump: pc <= wd aligned at update phase
pc_a  in  1  branch enable
b_succ  in  1  branch condition true
wd  in  32  jump target (pc_w) or signed word offset (branch)
ld_en  in  1  instruction memory write enable
ld_addr  in  AW  word address for loader write
ld_data  in  32  loader write data
od  out  32  fetched instruction
pc  out  32  current program counter
od_valid  out  1  od holds the instruction at the current pc
phase  out  PW  current phase counter value
fault  out  1  sticky out-of-range fetch flag

Behaviour:
- Reset (posedge with reset=1): pc=RESET_PC, od=0, od_valid=0, phase=0, fault=0. Reset overrides stall, fetch and update. Memory contents are not cleared.
- Loader: ld_en=1 writes M[ld_addr]<=ld_data on any edge, including during reset and stall. A same-edge fetch from the same address returns the old data.
- Phase counter: if stall=1, hold. Otherwise phase <= (phase==PHASES-1) ? 0 : phase+1.
- All actions below use the phase value before the edge and require stall=0 and reset=0.
- Fetch (phase==FETCH_PHASE), in-range pc (pc[31:AW+2]==0): od<=M[pc[AW+1:2]], od_valid<=1.
- Fetch, out-of-range pc: od<=32'h0 (NOP), od_valid<=1, fault<=1.
- fault stays set until reset.
- pc[1:0] is always 0, so no misalignment check is needed.
- Update (phase==UPDATE_PHASE), priority order:
  - pc_w=1: pc<={wd[31:2],2'b00}; pc_a and b_succ are ignored.
  - else pc_a&&b_succ: pc<=pc+4+(wd<<2).
  - else: pc<=pc+4.
  - All arithmetic is 32-bit, modulo 2^32 (wraps, no flag).
- Update also clears od_valid; od keeps its old value.
- Latency from reset release: fetch on the 2nd edge (od_valid=1), pc update on the 6th edge, next fetch on the 8th edge (defaults).
- Simultaneous events:
  - stall and reset both high: reset wins.
  - Control inputs outside UPDATE_PHASE have no effect.
- Optional simulation $display on each update: "ifu: pc<pc> od0x<od>".

Test Plan:
1. Under reset, load M[0]=0x00228021 and M[1]=0x00228823, then release -> edge 2: od=0x00228021, od_valid=1; edge 6: pc=4, od_valid=0; edge 8: od=0x00228823, phase sequence 0,1,2,3,4,5,0.
2. Branch at pc=0x20 with pc_a=1, b_succ=1, wd=0x00000004 -> pc=0x34. Repeat from pc=0x20 with wd=0xFFFFFFFE -> pc=0x1C. Repeat with b_succ=0 -> pc=0x24.
3. Jump with pc_w=1, pc_a=1, b_succ=1, wd=0x00000043 -> pc=0x40 (jump wins, low bits cleared). Next fetch returns M[16].
4. Assert stall for 3 edges while phase=1 -> phase stays 1, od/pc/od_valid unchanged. After release, fetch occurs on the next edge; total instruction cycle is 9 clocks.
5. Jump to wd=0x80 with IMEM_DEPTH=32 -> next fetch gives od=0, od_valid=1, fault=1. fault stays 1 after jumping back to 0x0; reset clears it.
6. Assert reset for 1 edge at phase=3, pc=0x08 -> pc=0, phase=0, od=0, od_valid=0. M contents preserved: next fetch returns M[0]. A ld_en write during reset takes effect.
